// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller for the 1x3 router
// Inputs : clock, resetn (sync, active-low), pkt_valid, data_in[1:0] header address,
//          fifo_full (selected FIFO), fifo_empty_0..2, soft_reset_0..2,
//          parity_done, low_pkt_valid
// Outputs: busy, detect_add, lfd_state, ld_state, laf_state, full_state,
//          write_enb_reg, rst_int_reg, port_sel[1:0] latched destination
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic [1:0] port_sel
);
  typedef enum logic [2:0] {
    DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE,
    LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY
  } state_t;
  state_t state_q, state_d;
  logic [1:0] port_sel_q, port_sel_d;
  // bit 3 padded with 0 so address 3 indexes a defined, inactive flag
  logic [3:0] empty_v, soft_v;
  assign empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_v  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  always_comb begin
    state_d = state_q;
    port_sel_d = port_sel_q;
    if (soft_v[port_sel_q]) state_d = DECODE_ADDRESS;
    else
      case (state_q)
        DECODE_ADDRESS:
          if (pkt_valid && data_in != 2'd3) begin
            port_sel_d = data_in;
            state_d = empty_v[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        LOAD_FIRST_DATA:    state_d = LOAD_DATA;
        LOAD_DATA:          state_d = fifo_full ? FIFO_FULL_STATE : (pkt_valid ? LOAD_DATA : LOAD_PARITY);
        FIFO_FULL_STATE:    state_d = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:    state_d = parity_done ? DECODE_ADDRESS : (low_pkt_valid ? LOAD_PARITY : LOAD_DATA);
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:    state_d = empty_v[port_sel_q] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        default:            state_d = DECODE_ADDRESS;
      endcase
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      port_sel_q <= 2'd0;
    end else begin
      state_q <= state_d;
      port_sel_q <= port_sel_d;
    end
  end
  assign detect_add    = state_q == DECODE_ADDRESS;
  assign lfd_state     = state_q == LOAD_FIRST_DATA;
  assign ld_state      = state_q == LOAD_DATA;
  assign laf_state     = state_q == LOAD_AFTER_FULL;
  assign full_state    = state_q == FIFO_FULL_STATE;
  assign rst_int_reg   = state_q == CHECK_PARITY_ERROR;
  assign write_enb_reg = ld_state || laf_state || state_q == LOAD_PARITY;
  assign busy          = !(detect_add || ld_state);
  assign port_sel      = port_sel_q;
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: vector table, hand sequences and randomized check against a phase model
module tb_router_fsm;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic pkt_valid = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic fifo_full = 1'b0;
  logic fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
  logic soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic parity_done = 1'b0, low_pkt_valid = 1'b0;
  logic busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg;
  logic [1:0] port_sel;
  logic [7:0] outs;
  int checks = 0, errors = 0;
  // output patterns {busy,detect,lfd,ld,laf,full,wen,rst_int}
  localparam logic [7:0] O_DEC = 8'b0100_0000, O_LFD = 8'b1010_0000, O_LD  = 8'b0001_0010,
                         O_LAF = 8'b1000_1010, O_FUL = 8'b1000_0100, O_LP  = 8'b1000_0010,
                         O_CPE = 8'b1000_0001, O_WTE = 8'b1000_0000;
  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .port_sel(port_sel)
  );
  always #5 clock = ~clock;
  assign outs = {busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg};
  typedef struct {
    logic pv; logic [1:0] din; logic ff; logic [2:0] emp; logic [2:0] sr;
    logic pd; logic lpv; logic [7:0] eo; logic [1:0] eps;
  } vec_t;
  vec_t tbl[$];
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask
  task automatic drive(input logic pv, input logic [1:0] din, input logic ff, input logic [2:0] emp,
                       input logic [2:0] sr, input logic pd, input logic lpv);
    pkt_valid = pv; data_in = din; fifo_full = ff;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
    {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
    parity_done = pd; low_pkt_valid = lpv;
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic add(input logic pv, input logic [1:0] din, input logic ff, input logic [2:0] emp,
                     input logic [2:0] sr, input logic pd, input logic lpv, input logic [7:0] eo,
                     input logic [1:0] eps);
    tbl.push_back('{pv, din, ff, emp, sr, pd, lpv, eo, eps});
  endtask
  // reference model: packet phase named by string, advanced by the protocol rules
  string m_st;
  logic [1:0] m_ps;
  function automatic logic [7:0] exp_of(input string s);
    case (s)
      "LFD": return O_LFD;
      "LD":  return O_LD;
      "LAF": return O_LAF;
      "FUL": return O_FUL;
      "LP":  return O_LP;
      "CPE": return O_CPE;
      "WTE": return O_WTE;
      default: return O_DEC;
    endcase
  endfunction
  task automatic model_step;
    logic [2:0] emp;
    logic [2:0] sr;
    string n;
    emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    sr = {soft_reset_2, soft_reset_1, soft_reset_0};
    n = m_st;
    if (!resetn) begin
      n = "DEC"; m_ps = 2'd0;
    end else if (m_ps < 3 && sr[m_ps]) n = "DEC";
    else if (m_st == "DEC") begin
      if (pkt_valid && data_in < 3) begin
        m_ps = data_in;
        n = emp[data_in] ? "LFD" : "WTE";
      end
    end else if (m_st == "LFD") n = "LD";
    else if (m_st == "LD") n = fifo_full ? "FUL" : (!pkt_valid ? "LP" : "LD");
    else if (m_st == "FUL") n = fifo_full ? "FUL" : "LAF";
    else if (m_st == "LAF") n = parity_done ? "DEC" : (low_pkt_valid ? "LP" : "LD");
    else if (m_st == "LP") n = "CPE";
    else if (m_st == "CPE") n = fifo_full ? "FUL" : "DEC";
    else if (m_st == "WTE") n = emp[m_ps] ? "LFD" : "WTE";
    m_st = n;
  endtask
  initial begin
    // normal packet to port 1
    add(1, 1, 0, 3'b010, 0, 0, 0, O_LFD, 1);
    add(1, 1, 0, 3'b010, 0, 0, 0, O_LD, 1);
    add(1, 0, 0, 3'b010, 0, 0, 0, O_LD, 1);
    add(1, 2, 0, 3'b010, 0, 0, 0, O_LD, 1);
    add(1, 3, 0, 3'b010, 0, 0, 0, O_LD, 1);
    add(0, 0, 0, 3'b010, 0, 0, 0, O_LP, 1);
    add(0, 0, 0, 3'b010, 0, 0, 0, O_CPE, 1);
    add(0, 0, 0, 3'b010, 0, 0, 0, O_DEC, 1);
    // wait for port 2 to drain
    add(1, 2, 0, 3'b000, 0, 0, 0, O_WTE, 2);
    for (int i = 0; i < 4; i++) add(1, 2, 0, 3'b000, 0, 0, 0, O_WTE, 2);
    add(1, 2, 0, 3'b100, 0, 0, 0, O_LFD, 2);
    add(1, 2, 0, 3'b100, 0, 0, 0, O_LD, 2);
    // full stall then resume payload
    for (int i = 0; i < 3; i++) add(1, 0, 1, 3'b100, 0, 0, 0, O_FUL, 2);
    add(1, 0, 0, 3'b100, 0, 0, 0, O_LAF, 2);
    add(1, 0, 0, 3'b100, 0, 0, 0, O_LD, 2);
    // full stall then low_pkt_valid into parity
    add(1, 0, 1, 3'b100, 0, 0, 0, O_FUL, 2);
    add(1, 0, 0, 3'b100, 0, 0, 0, O_LAF, 2);
    add(1, 0, 0, 3'b100, 0, 0, 1, O_LP, 2);
    add(0, 0, 0, 3'b100, 0, 0, 0, O_CPE, 2);
    add(0, 0, 0, 3'b100, 0, 0, 0, O_DEC, 2);
    // full stall then parity_done straight to decode
    add(1, 0, 0, 3'b001, 0, 0, 0, O_LFD, 0);
    add(1, 0, 0, 3'b001, 0, 0, 0, O_LD, 0);
    add(1, 0, 1, 3'b001, 0, 0, 0, O_FUL, 0);
    add(1, 0, 0, 3'b001, 0, 0, 0, O_LAF, 0);
    add(1, 0, 0, 3'b001, 0, 1, 0, O_DEC, 0);
    // soft reset: other port ignored, selected port aborts
    add(1, 0, 0, 3'b001, 0, 0, 0, O_LFD, 0);
    add(1, 0, 0, 3'b001, 0, 0, 0, O_LD, 0);
    add(1, 0, 1, 3'b001, 0, 0, 0, O_FUL, 0);
    add(1, 0, 1, 3'b001, 3'b010, 0, 0, O_FUL, 0);
    add(1, 0, 1, 3'b001, 3'b001, 0, 0, O_DEC, 0);
    // invalid address
    for (int i = 0; i < 3; i++) add(1, 3, 0, 3'b111, 0, 0, 0, O_DEC, 0);
    // parity check sees full FIFO
    add(1, 1, 0, 3'b111, 0, 0, 0, O_LFD, 1);
    add(0, 1, 0, 3'b111, 0, 0, 0, O_LD, 1);
    add(0, 1, 0, 3'b111, 0, 0, 0, O_LP, 1);
    add(0, 1, 1, 3'b111, 0, 0, 0, O_CPE, 1);
    add(0, 1, 1, 3'b111, 0, 0, 0, O_FUL, 1);
    add(0, 1, 0, 3'b111, 0, 1, 0, O_LAF, 1);
    add(0, 1, 0, 3'b111, 0, 1, 0, O_DEC, 1);
    resetn = 1'b0;
    tick();
    tick();
    check("reset_outs", outs, O_DEC);
    check("reset_port_sel", {6'd0, port_sel}, 8'd0);
    resetn = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].pv, tbl[i].din, tbl[i].ff, tbl[i].emp, tbl[i].sr, tbl[i].pd, tbl[i].lpv);
      tick();
      check($sformatf("vec%0d_outs", i), outs, tbl[i].eo);
      check($sformatf("vec%0d_port_sel", i), {6'd0, port_sel}, {6'd0, tbl[i].eps});
    end
    // hard reset in the middle of a payload
    drive(1, 1, 0, 3'b010, 0, 0, 0);
    tick();
    tick();
    tick();
    check("midpkt_ld", outs, O_LD);
    resetn = 1'b0;
    tick();
    check("midpkt_rst1_outs", outs, O_DEC);
    tick();
    check("midpkt_rst2_outs", outs, O_DEC);
    check("midpkt_rst_port_sel", {6'd0, port_sel}, 8'd0);
    resetn = 1'b1;
    drive(0, 1, 0, 3'b010, 0, 0, 0);
    tick();
    check("midpkt_idle", outs, O_DEC);
    // randomized run against the phase model
    m_st = "DEC";
    m_ps = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      resetn = !($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
            3'($urandom_range(0, 7)),
            {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0},
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      model_step();
      tick();
      check($sformatf("rnd%0d_outs_%s", i, m_st), outs, exp_of(m_st));
      check($sformatf("rnd%0d_port_sel", i), {6'd0, port_sel}, {6'd0, m_ps});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
